// File: rtl/dht11_sample_scheduler.sv
// DHT11 read scheduler: power-up settle, periodic and forced sampling with a
// minimum start-to-start gap, per-transaction timeout, bounded retries, result hold.
module dht11_sample_scheduler #(
  parameter int unsigned POWERUP_CYC = 32'd50_000_000,
  parameter int unsigned PERIOD_CYC  = 32'd100_000_000,
  parameter int unsigned MIN_GAP_CYC = 32'd50_000_000,
  parameter int unsigned TIMEOUT_CYC = 32'd2_500_000,
  parameter int unsigned RETRY_CYC   = 32'd50_000_000,
  parameter int unsigned MAX_RETRIES = 32'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        force_req,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic        rd_ok,
  input  logic [7:0]  rd_temp,
  input  logic [7:0]  rd_hum,
  output logic [7:0]  temperature,
  output logic [7:0]  humidity,
  output logic        valid,
  output logic        fault,
  output logic        busy,
  output logic [15:0] sample_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    ST_POWERUP    = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WAIT       = 3'd2,
    ST_START      = 3'd3,
    ST_BUSY       = 3'd4,
    ST_RETRY_WAIT = 3'd5
  } state_t;

  localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYC - 32'd1);
  localparam logic [31:0] PERIOD_MAX   = 32'(PERIOD_CYC);
  localparam logic [31:0] GAP_MAX      = 32'(MIN_GAP_CYC);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 32'd1);
  localparam logic [31:0] RETRY_LAST   = 32'(RETRY_CYC - 32'd1);
  localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRIES);
  localparam logic [7:0]  TEMP_INVALID = 8'd99;

  state_t      state_r, state_next_s;
  logic [31:0] phase_cnt_r, period_cnt_r, gap_cnt_r, timeout_cnt_r;
  logic [7:0]  retry_r;
  logic        force_pend_r;
  logic        start_s, done_ok_s, fail_s, gap_ok_s, retry_left_s;
  logic        rd_start_r, busy_r, valid_r, fault_r;
  logic [7:0]  temperature_r, humidity_r, err_cnt_r;
  logic [15:0] sample_cnt_r;

  assign gap_ok_s     = (gap_cnt_r >= GAP_MAX);
  assign retry_left_s = (retry_r < RETRY_LIMIT);
  assign start_s      = (state_next_s == ST_START);

  // Transaction outcome; a done arriving with the timeout wins over the timeout
  always_comb begin
    done_ok_s = 1'b0;
    fail_s    = 1'b0;
    if (state_r == ST_BUSY) begin
      done_ok_s = rd_done & rd_ok;
      fail_s    = (rd_done & ~rd_ok) | (~rd_done & (timeout_cnt_r == TIMEOUT_LAST));
    end else begin
      done_ok_s = 1'b0;
      fail_s    = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_POWERUP: begin
        if (phase_cnt_r == POWERUP_LAST) state_next_s = enable ? ST_START : ST_IDLE;
        else                             state_next_s = ST_POWERUP;
      end
      ST_IDLE: begin
        if (enable) state_next_s = gap_ok_s ? ST_START : ST_WAIT;
        else        state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (!enable)                                                  state_next_s = ST_IDLE;
        else if ((period_cnt_r == PERIOD_MAX) || (force_pend_r && gap_ok_s)) state_next_s = ST_START;
        else                                                          state_next_s = ST_WAIT;
      end
      ST_START: state_next_s = ST_BUSY;
      ST_BUSY: begin
        if (done_ok_s)         state_next_s = enable ? ST_WAIT : ST_IDLE;
        else if (fail_s)       state_next_s = retry_left_s ? ST_RETRY_WAIT : (enable ? ST_WAIT : ST_IDLE);
        else                   state_next_s = ST_BUSY;
      end
      ST_RETRY_WAIT: begin
        if (!enable)                       state_next_s = ST_IDLE;
        else if (phase_cnt_r == RETRY_LAST) state_next_s = ST_START;
        else                               state_next_s = ST_RETRY_WAIT;
      end
      default: state_next_s = ST_POWERUP;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_POWERUP;
    else        state_r <= state_next_s;
  end

  // Interval counters; period and gap count the start cycle itself so they read N on the N-th cycle after it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt_r   <= 32'd0;
      period_cnt_r  <= 32'd0;
      gap_cnt_r     <= 32'd0;
      timeout_cnt_r <= 32'd0;
    end else begin
      if (state_next_s != state_r)                                  phase_cnt_r <= 32'd0;
      else if ((state_r == ST_POWERUP) || (state_r == ST_RETRY_WAIT)) phase_cnt_r <= phase_cnt_r + 32'd1;
      else                                                          phase_cnt_r <= 32'd0;

      if (start_s)                        period_cnt_r <= 32'd1;
      else if (period_cnt_r < PERIOD_MAX) period_cnt_r <= period_cnt_r + 32'd1;
      else                                period_cnt_r <= period_cnt_r;

      if (start_s)                  gap_cnt_r <= 32'd1;
      else if (gap_cnt_r < GAP_MAX) gap_cnt_r <= gap_cnt_r + 32'd1;
      else                          gap_cnt_r <= gap_cnt_r;

      if (state_r == ST_START)     timeout_cnt_r <= 32'd0;
      else if (state_r == ST_BUSY) timeout_cnt_r <= timeout_cnt_r + 32'd1;
      else                         timeout_cnt_r <= timeout_cnt_r;
    end
  end

  // Force request capture and retry tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      force_pend_r <= 1'b0;
      retry_r      <= 8'd0;
    end else begin
      if (start_s)                                                   force_pend_r <= 1'b0;
      else if (force_req && (state_r != ST_START) && (state_r != ST_BUSY)) force_pend_r <= 1'b1;
      else                                                           force_pend_r <= force_pend_r;

      if (done_ok_s)                                  retry_r <= 8'd0;
      else if (fail_s)                                retry_r <= retry_left_s ? (retry_r + 8'd1) : 8'd0;
      else if ((state_r == ST_RETRY_WAIT) && !enable) retry_r <= 8'd0;
      else                                            retry_r <= retry_r;
    end
  end

  // Result, status and statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      temperature_r <= TEMP_INVALID;
      humidity_r    <= 8'd0;
      valid_r       <= 1'b0;
      fault_r       <= 1'b0;
      sample_cnt_r  <= 16'd0;
      err_cnt_r     <= 8'd0;
    end else if (done_ok_s) begin
      temperature_r <= rd_temp;
      humidity_r    <= rd_hum;
      valid_r       <= 1'b1;
      fault_r       <= 1'b0;
      sample_cnt_r  <= sample_cnt_r + 16'd1;
    end else if (fail_s) begin
      err_cnt_r <= (err_cnt_r == 8'd255) ? err_cnt_r : (err_cnt_r + 8'd1);
      if (!retry_left_s) begin
        fault_r       <= 1'b1;
        valid_r       <= 1'b0;
        temperature_r <= TEMP_INVALID;
        humidity_r    <= 8'd0;
      end
    end
  end

  // Registered handshake and busy flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rd_start_r <= start_s;
      busy_r     <= (state_next_s == ST_BUSY);
    end
  end

  assign rd_start    = rd_start_r;
  assign busy        = busy_r;
  assign valid       = valid_r;
  assign fault       = fault_r;
  assign temperature = temperature_r;
  assign humidity    = humidity_r;
  assign sample_cnt  = sample_cnt_r;
  assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_dht11_sample_scheduler.sv
// Bench for dht11_sample_scheduler: directed sequence with randomized reader replies,
// expected start times and outputs come from an arithmetic model of the scheduling rules.
module tb_dht11_sample_scheduler;
  localparam int PU  = 10;
  localparam int PER = 40;
  localparam int GAP = 20;
  localparam int TO  = 15;
  localparam int RET = 20;
  localparam int MR  = 2;

  logic        clk = 1'b0;
  logic        reset, enable, force_req, rd_start, rd_done, rd_ok;
  logic [7:0]  rd_temp, rd_hum, temperature, humidity, err_cnt;
  logic        valid, fault, busy;
  logic [15:0] sample_cnt;

  dht11_sample_scheduler #(
    .POWERUP_CYC(PU), .PERIOD_CYC(PER), .MIN_GAP_CYC(GAP),
    .TIMEOUT_CYC(TO), .RETRY_CYC(RET), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .force_req(force_req),
    .rd_start(rd_start), .rd_done(rd_done), .rd_ok(rd_ok),
    .rd_temp(rd_temp), .rd_hum(rd_hum), .temperature(temperature),
    .humidity(humidity), .valid(valid), .fault(fault), .busy(busy),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rel = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  m_temp, m_hum;
  logic        m_valid, m_fault;
  logic [15:0] m_scnt;
  int          m_ecnt, m_retry, exp_start, last_s;

  function automatic int now();
    return cyc - rel;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_temp = 8'd99; m_hum = 8'd0; m_valid = 1'b0; m_fault = 1'b0;
    m_scnt = 16'd0; m_ecnt = 0; m_retry = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_temp"},  32'(temperature), 32'(m_temp));
    chk({tag, "_hum"},   32'(humidity),    32'(m_hum));
    chk({tag, "_valid"}, 32'(valid),       32'(m_valid));
    chk({tag, "_fault"}, 32'(fault),       32'(m_fault));
    chk({tag, "_scnt"},  32'(sample_cnt),  32'(m_scnt));
    chk({tag, "_ecnt"},  32'(err_cnt),     32'(m_ecnt));
    chk({tag, "_busy"},  32'(busy),        32'd0);
  endtask

  task automatic wait_start(input int bound, output int s);
    s = -1;
    for (int k = 0; k < bound; k++) begin
      tick(1);
      if (rd_start === 1'b1) begin
        s = now();
        break;
      end
    end
  endtask

  task automatic pulse_force();
    force_req = 1'b1;
    tick(1);
    force_req = 1'b0;
  endtask

  // mode 0: good frame, 1: checksum error, 2: no reply (timeout)
  task automatic do_txn(input int mode, input int d, input bit drop_en, input string tag);
    int s, f;
    logic [7:0] t, h;
    t = 8'($urandom);
    h = 8'($urandom);
    if (tag == "first") begin
      t = 8'd25;
      h = 8'd60;
    end
    wait_start(PER + RET + 10, s);
    chk({tag, "_start_edge"}, 32'(s), 32'(exp_start));
    if (s < 0) s = now();
    last_s = s;
    if (drop_en) enable = 1'b0;
    tick(1);
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    chk({tag, "_start_1cyc"}, 32'(rd_start), 32'd0);
    if (mode == 2) begin
      tick(TO);
    end else begin
      tick(d - 1);
      rd_done = 1'b1; rd_ok = (mode == 0); rd_temp = t; rd_hum = h;
      tick(1);
      rd_done = 1'b0; rd_ok = 1'b0;
    end
    f = now();
    if (mode == 0) begin
      m_temp = t; m_hum = h; m_valid = 1'b1; m_fault = 1'b0; m_retry = 0;
      m_scnt = m_scnt + 16'd1;
      exp_start = s + PER;
    end else begin
      if (m_ecnt < 255) m_ecnt++;
      if (m_retry < MR) begin
        m_retry++;
        exp_start = f + RET;
      end else begin
        m_fault = 1'b1; m_valid = 1'b0; m_temp = 8'd99; m_hum = 8'd0; m_retry = 0;
        exp_start = s + PER;
      end
    end
    check_outputs(tag);
    if (mode == 2) begin
      tick(2);
      rd_done = 1'b1; rd_ok = 1'b1; rd_temp = 8'($urandom);
      tick(1);
      rd_done = 1'b0; rd_ok = 1'b0;
      chk({tag, "_late_valid"}, 32'(valid), 32'(m_valid));
      chk({tag, "_late_scnt"},  32'(sample_cnt), 32'(m_scnt));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, cnt, t0;
    reset = 1'b0; enable = 1'b1; force_req = 1'b0;
    rd_done = 1'b0; rd_ok = 1'b0; rd_temp = 8'd0; rd_hum = 8'd0;
    model_reset();
    tick(3);
    check_outputs("reset");
    chk("reset_rd_start", 32'(rd_start), 32'd0);

    reset = 1'b1;
    rel = cyc;
    exp_start = PU;
    do_txn(0, TO, 1'b0, "first");

    // Forced sample waits for the minimum gap; repeated requests coalesce
    do_txn(0, 1, 1'b0, "pre_force");
    tick(last_s + 5 - now());
    pulse_force();
    tick(1);
    pulse_force();
    tick(3);
    pulse_force();
    exp_start = last_s + GAP;
    do_txn(0, $urandom_range(1, 5), 1'b0, "forced");
    do_txn(0, $urandom_range(1, TO), 1'b0, "after_force");

    // Three checksum failures end in fault; a good frame clears it
    do_txn(1, $urandom_range(1, TO), 1'b0, "cks1");
    do_txn(1, $urandom_range(1, TO), 1'b0, "cks2");
    do_txn(1, $urandom_range(1, TO), 1'b0, "cks3");
    do_txn(0, $urandom_range(1, TO), 1'b0, "recover");

    do_txn(2, 1, 1'b0, "timeout");
    do_txn(0, $urandom_range(1, TO), 1'b0, "post_to");

    for (int i = 0; i < 8; i++) begin
      do_txn($urandom_range(0, 2), $urandom_range(1, TO), 1'b0, "rand");
    end
    do_txn(0, $urandom_range(1, TO), 1'b0, "settle");

    // Disable during a transaction: it completes, then no further starts
    do_txn(0, 3, 1'b1, "drop_en");
    cnt = 0;
    repeat (60) begin
      tick(1);
      if (rd_start === 1'b1) cnt++;
    end
    chk("idle_no_start", 32'(cnt), 32'd0);
    enable = 1'b1;
    t0 = now();
    exp_start = t0 + 1;
    do_txn(0, $urandom_range(1, TO), 1'b0, "reenable");

    // Reset in BUSY abandons the transaction
    wait_start(PER + RET + 10, s);
    chk("rst_busy_start_edge", 32'(s), 32'(exp_start));
    tick(2);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_busy");
    chk("rst_busy_rd_start", 32'(rd_start), 32'd0);
    rd_done = 1'b1; rd_ok = 1'b1; rd_temp = 8'd42;
    tick(1);
    rd_done = 1'b0; rd_ok = 1'b0;
    reset = 1'b1;
    rel = cyc;
    tick(2);
    rd_done = 1'b1; rd_ok = 1'b1;
    tick(1);
    rd_done = 1'b0; rd_ok = 1'b0;
    check_outputs("powerup_ignore_done");

    // Sample counter wrap from a preloaded 0xFFFF
    force dut.sample_cnt_r = 16'hFFFF;
    tick(1);
    release dut.sample_cnt_r;
    m_scnt = 16'hFFFF;
    exp_start = PU;
    do_txn(0, $urandom_range(1, TO), 1'b0, "wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
